// File: rtl/result_reader.sv
// Result buffer: collects an N x N matrix of signed results written one per W_en cycle,
// then streams them out in row-major order over a valid/ready interface.
// Optional feature: define RESULT_READER_CHECKSUM_EN to add a 24-bit signed checksum
// output accumulating every element accepted downstream since the last start.
module result_reader #(
  parameter int unsigned N  = 10,
  parameter int unsigned DW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 W_en,
  input  logic signed [DW-1:0] R_ij,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_data,
  output logic [3:0]           out_row,
  output logic [3:0]           out_col,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow
`ifdef RESULT_READER_CHECKSUM_EN
  ,
  output logic signed [23:0]   checksum
`endif
);

  localparam int unsigned Depth = N * N;
  localparam int unsigned AW    = (Depth > 1) ? $clog2(Depth + 1) : 1;
  localparam logic [AW-1:0] LastIdx = AW'(Depth - 1);
  localparam logic [3:0]    LastCol = 4'(N - 1);

  typedef enum logic [1:0] {StIdle, StFill, StDrain} state_e;

  state_e              state_q, state_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [3:0]          rd_row_q, rd_row_d;
  logic [3:0]          rd_col_q, rd_col_d;
  logic                out_valid_q, out_valid_d;
  logic signed [DW-1:0] out_data_q, out_data_d;
  logic [3:0]          out_row_q, out_row_d;
  logic [3:0]          out_col_q, out_col_d;
  logic                out_last_q, out_last_d;
  logic                done_q, done_d;
  logic                overflow_q, overflow_d;
  logic                mem_we;
  logic                handshake;

  logic signed [DW-1:0] mem [Depth];

`ifdef RESULT_READER_CHECKSUM_EN
  logic signed [23:0] cks_q, cks_d;
`endif

  assign mem_we    = (state_q == StFill) && W_en;
  assign handshake = out_valid_q && out_ready;

  // Result storage; writes only land during FILL so DRAIN-time strobes cannot corrupt it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr_q] <= R_ij;
    end
  end

  // Next-state and output-register logic for the IDLE/FILL/DRAIN controller.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    rd_row_d    = rd_row_q;
    rd_col_d    = rd_col_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    overflow_d  = overflow_q;
`ifdef RESULT_READER_CHECKSUM_EN
    cks_d       = cks_q;
    if (handshake) begin
      cks_d = cks_q + 24'(out_data_q);
    end
`endif

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StFill;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          rd_row_d   = '0;
          rd_col_d   = '0;
          overflow_d = 1'b0;
`ifdef RESULT_READER_CHECKSUM_EN
          cks_d      = '0;
`endif
        end
      end

      StFill: begin
        if (W_en) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (wr_ptr_q == LastIdx) begin
            state_d = StDrain;
          end
        end
      end

      StDrain: begin
        if (W_en) begin
          overflow_d = 1'b1;
        end
        if (handshake && out_last_q) begin
          state_d     = StIdle;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          done_d      = 1'b1;
        end else if (!out_valid_q || out_ready) begin
          // Output register is empty or being drained this cycle: load the next element.
          out_valid_d = 1'b1;
          out_data_d  = mem[rd_ptr_q];
          out_row_d   = rd_row_q;
          out_col_d   = rd_col_q;
          out_last_d  = (rd_ptr_q == LastIdx);
          rd_ptr_d    = rd_ptr_q + 1'b1;
          if (rd_col_q == LastCol) begin
            rd_col_d = '0;
            rd_row_d = rd_row_q + 1'b1;
          end else begin
            rd_col_d = rd_col_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rd_row_q    <= '0;
      rd_col_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_row_q    <= rd_row_d;
      rd_col_q    <= rd_col_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
    end
  end

`ifdef RESULT_READER_CHECKSUM_EN
  // Running sum of accepted elements.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cks_q <= '0;
    end else begin
      cks_q <= cks_d;
    end
  end

  assign checksum = cks_q;
`endif

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_result_reader.sv
// Self-checking bench for result_reader: scoreboard of expected stream elements filled
// as results are written, compared as the DUT presents them.
module tb_result_reader;

  localparam int N  = 10;
  localparam int DW = 16;
  localparam int NN = N * N;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 W_en;
  logic signed [DW-1:0] R_ij;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_data;
  logic [3:0]           out_row;
  logic [3:0]           out_col;
  logic                 out_last;
  logic                 busy;
  logic                 done;
  logic                 overflow;
`ifdef RESULT_READER_CHECKSUM_EN
  logic signed [23:0]   checksum;
`endif

  typedef struct packed {
    logic [DW-1:0] d;
    logic [3:0]    r;
    logic [3:0]    c;
    logic          last;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  result_reader #(.N(N), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .W_en      (W_en),
    .R_ij      (R_ij),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow)
`ifdef RESULT_READER_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] gen(input int mode, input int k);
    case (mode)
      0:       return DW'(45 * (k % 10));
      1:       return '1;
      default: return DW'(1000 + 3 * k);
    endcase
  endfunction

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Writes count results; the final negedge is one edge after the last write.
  task automatic fill(input int mode, input int count);
    exp_t e;
    for (int k = 0; k < count; k++) begin
      if (mode == 2 && (k % 7) == 3) begin
        @(negedge clk);
        W_en = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL fill_valid k=%0d: out_valid=%b want 0", k, out_valid);
      end
      W_en = 1'b1;
      R_ij = gen(mode, k);
      e.d = gen(mode, k);
      e.r = 4'(k / N);
      e.c = 4'(k % N);
      e.last = (k == NN - 1);
      exp_q.push_back(e);
    end
    @(negedge clk);
    W_en = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: out_valid=%b want 0 right after final write", out_valid);
    end
  endtask

  // rmode 0: ready always high; 1: ready pattern 1,0,0 repeating.
  task automatic drain(input int rmode, input int inj_at, input int start_at);
    exp_t e;
    bit fin = 0;
    int i = 0;
    logic pv = 0, pr = 0, plast = 0;
    logic [DW-1:0] pd = '0;
    logic [3:0] prow = '0, pcol = '0;
    while (!fin && i < 2000) begin
      @(negedge clk);
      W_en = (i == inj_at);
      R_ij = 16'sh7FFF;
      start = (i == start_at);
      out_ready = (rmode == 0) ? 1'b1 : ((i % 3) == 0);
      if (i == 0) begin
        checks++;
        if (out_valid !== 1'b1) begin
          errors++;
          $display("FAIL latency: out_valid=%b want 1 one cycle after final write", out_valid);
        end
      end
      if (pv && !pr) begin
        checks++;
        if ({out_valid, out_data, out_row, out_col, out_last} !== {1'b1, pd, prow, pcol, plast}) begin
          errors++;
          $display("FAIL hold: got v=%b d=%0h r=%0d c=%0d l=%b want v=1 d=%0h r=%0d c=%0d l=%b",
                   out_valid, out_data, out_row, out_col, out_last, pd, prow, pcol, plast);
        end
      end
      if (out_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_element: got d=%0h with empty scoreboard, want none", out_data);
          fin = 1;
        end else begin
          e = exp_q[0];
          if ({out_data, out_row, out_col, out_last} !== {e.d, e.r, e.c, e.last}) begin
            errors++;
            $display("FAIL stream: got d=%0h r=%0d c=%0d l=%b want d=%0h r=%0d c=%0d l=%b",
                     out_data, out_row, out_col, out_last, e.d, e.r, e.c, e.last);
          end
          if (out_ready) begin
            void'(exp_q.pop_front());
            if (e.last) fin = 1;
          end
        end
      end
      pv = out_valid; pr = out_ready; pd = out_data;
      prow = out_row; pcol = out_col; plast = out_last;
      i++;
    end
    @(negedge clk);
    W_en = 1'b0;
    start = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL drain_timeout: %0d elements left, want 0", exp_q.size());
    end
    checks++;
    if ({done, out_valid, busy} !== 3'b100) begin
      errors++;
      $display("FAIL done_pulse: got done=%b valid=%b busy=%b want 1 0 0", done, out_valid, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_width: done=%b want 0 second cycle", done);
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; W_en = 1'b0; R_ij = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({out_valid, out_data, out_row, out_col, out_last, busy, done, overflow} !== '0) begin
      errors++;
      $display("FAIL reset: got v=%b d=%0h r=%0d c=%0d l=%b busy=%b done=%b ovf=%b want all 0",
               out_valid, out_data, out_row, out_col, out_last, busy, done, overflow);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stream();
    do_start();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_fill: busy=%b want 1", busy);
    end
    fill(0, NN);
    drain(0, -1, -1);
`ifdef RESULT_READER_CHECKSUM_EN
    checks++;
    if (checksum !== 24'sd20250) begin
      errors++;
      $display("FAIL checksum_pos: got %0d want 20250", checksum);
    end
    @(negedge clk);
    checks++;
    if (checksum !== 24'sd20250) begin
      errors++;
      $display("FAIL checksum_stable: got %0d want 20250", checksum);
    end
`endif
  endtask

  task automatic test_backpressure();
    do_start();
    fill(0, NN);
    drain(1, -1, -1);
  endtask

  task automatic test_overflow();
    do_start();
    fill(0, NN);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_pre: overflow=%b want 0", overflow);
    end
    drain(0, 3, -1);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_set: overflow=%b want 1", overflow);
    end
    do_start();
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clear: overflow=%b want 0 after start", overflow);
    end
    fill(2, NN);
    drain(0, -1, -1);
  endtask

  task automatic test_mid_reset();
    do_start();
    fill(0, 50);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_data, out_row, out_col, out_last, busy, done, overflow} !== '0) begin
      errors++;
      $display("FAIL mid_reset: got v=%b d=%0h busy=%b done=%b ovf=%b want all 0",
               out_valid, out_data, busy, done, overflow);
    end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL reset_no_done: busy=%b done=%b want 0 0", busy, done);
    end
    do_start();
    fill(2, NN);
    drain(0, -1, -1);
  endtask

  task automatic test_ignored_start();
    @(negedge clk);
    start = 1'b1; W_en = 1'b1; R_ij = 16'sh7FFF;
    @(negedge clk);
    start = 1'b0; W_en = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL idle_wen: overflow=%b want 0", overflow);
    end
    fill(0, NN);
    drain(1, -1, 5);
  endtask

  task automatic test_negative();
    do_start();
    fill(1, NN);
    drain(0, -1, -1);
`ifdef RESULT_READER_CHECKSUM_EN
    checks++;
    if (checksum !== -24'sd100) begin
      errors++;
      $display("FAIL checksum_neg: got %0d want -100", checksum);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_overflow();
    test_mid_reset();
    test_ignored_start();
    test_negative();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
